sdft_feeder: RTL and testbench
==============================

SDFT_FEEDER -- requirements
Module: sdft_feeder

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12, ADC sample width.
REQ-002 SHALL have parameter DATA_W, default 8, output sample width to sliding DFT.
REQ-003 SHALL have parameter DECIM, default 256, decimation factor; power of two, 1..1024.
REQ-004 SHALL have parameter GAIN_SHIFT, default 4, right shift applied after decimation.
REQ-005 SHALL have parameter DC_SHIFT, default 6, DC tracker time constant (log2).
REQ-006 clk  in  1  single clock (pixel clock domain).
REQ-007 resetn  in  1  reset; asynchronous assert, active-low.
REQ-008 adc_data  in  SAMPLE_WIDTH  unsigned ADC sample.
REQ-009 adc_valid  in  1  one-cycle strobe, adc_data valid.
REQ-010 sdft_ready  in  1  sliding DFT idle/ready for a sample.
REQ-011 sdft_start  out  1  request to process sdft_sample.
REQ-012 sdft_sample  out  DATA_W  signed two's-complement sample.
REQ-013 overrun  out  1  one-cycle pulse per dropped decimated sample.
REQ-014 overrun_count  out  8  saturating count of dropped samples.

Function
REQ-015 On adc_valid, centred = adc_data - dc, signed SAMPLE_WIDTH+1 bits.
REQ-016 Boxcar accumulator SHALL sum DECIM centred values, width SAMPLE_WIDTH+1+log2(DECIM); on the DECIM-th valid, avg = sum >>> log2(DECIM), sum cleared, window counter wraps to 0.
REQ-017 scaled = avg >>> GAIN_SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-018 Scaled result SHALL be registered into a one-entry pending buffer one cycle after the completing adc_valid.
REQ-019 Handshake FSM states: S_IDLE, S_START, S_BUSY.
REQ-020 S_IDLE: pending full and sdft_ready=1 -> load sdft_sample from pending, clear pending, sdft_start<=1, go S_START.
REQ-021 S_START: hold sdft_start=1 and sdft_sample stable until sdft_ready=0, then sdft_start<=0, go S_BUSY.
REQ-022 S_BUSY: on sdft_ready=1 go S_IDLE; sdft_sample held.
REQ-023 Minimum latency: completing adc_valid at cycle N -> sdft_start high at N+2 (pending at N+1, FSM idle, ready high).
REQ-024 New decimated result while pending full: newest dropped, pending kept, overrun pulses, overrun_count +1 saturating at 255.
REQ-025 Pending load and FSM consume in same cycle: consume wins, new result enters pending, no overrun.
REQ-026 adc_valid while sdft_start high SHALL still be accumulated; decimation never stalls.

Reset
REQ-027 resetn low: sdft_start=0, sdft_sample=0, overrun=0, overrun_count=0, pending empty, sum=0, window counter=0, FSM=S_IDLE, dc=2^(SAMPLE_WIDTH-1).
REQ-028 Reset mid-operation SHALL abandon the current window; first start after release only after a full DECIM window.

Configuration
REQ-029 Macro SDFT_FEEDER_DC_REMOVE_EN defined: dc from IIR tracker, acc += adc_data - (acc >> DC_SHIFT), dc = acc >> DC_SHIFT, acc reset to 2^(SAMPLE_WIDTH-1) << DC_SHIFT, updated on each adc_valid using old dc for centring.
REQ-030 Macro undefined: dc constant 2^(SAMPLE_WIDTH-1); no tracker logic; DC_SHIFT ignored.

Structure
REQ-031 Shared package sdft_pkg SHALL hold FSM state type, default SAMPLE_WIDTH/DATA_W constants, saturation width helper.
REQ-032 DC tracker SHALL be sub-module dc_tracker, instantiated only under SDFT_FEEDER_DC_REMOVE_EN.

Verification
REQ-033 No macro, DECIM=4, GAIN_SHIFT=4, 4 valids of adc_data=2208, sdft_ready=1 -> sdft_sample=10, sdft_start at N+2.
REQ-034 GAIN_SHIFT=2, DECIM=4: adc_data=4095 window -> 127; adc_data=0 window -> -128 (saturation).
REQ-035 sdft_ready stays high 5 cycles after start -> sdft_start high 5 cycles, falls cycle after ready low; sample unchanged until S_IDLE.
REQ-036 sdft_ready held low over 3 windows -> first held pending, overrun pulses twice, overrun_count=2; ready high -> pending delivered.
REQ-037 Macro on, DC_SHIFT=4, DECIM=4, constant adc_data=3000 for 400 valids -> final sdft_sample within +/-1 of 0.
REQ-038 resetn low in S_BUSY with half-filled window -> all outputs reset values; first start after 4 post-reset valids (DECIM=4).

Source files
------------

// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sample feeder.
//   fsm_state_t      handshake FSM state encoding
//   DEF_SAMPLE_WIDTH default ADC sample width
//   DEF_DATA_W       default sample width presented to the sliding DFT
//   centred_w()      width of a DC-centred sample (one sign bit above the ADC width)
package sdft_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } fsm_state_t;

  localparam int DEF_SAMPLE_WIDTH = 12;
  localparam int DEF_DATA_W       = 8;

  function automatic int centred_w(input int sample_width);
    return sample_width + 1;
  endfunction

endpackage

// File: rtl/dc_tracker.sv
// First-order IIR DC estimator for the ADC stream.
//   acc += adc_data - (acc >> DC_SHIFT); dc = acc >> DC_SHIFT
// The accumulator starts at mid-scale, so dc starts at 2^(SAMPLE_WIDTH-1).
// dc is a registered value: the sample that updates acc is centred with the
// previous estimate.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   adc_data        unsigned ADC sample
//   adc_valid       sample strobe
//   dc              current DC estimate
module dc_tracker
  import sdft_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DC_SHIFT     = 6
)(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  output logic [SAMPLE_WIDTH-1:0] dc
);

  // acc never exceeds 2^(SAMPLE_WIDTH+DC_SHIFT)-1 for any input sequence, so
  // no guard bit is needed; intermediate wrap cancels in modular arithmetic.
  localparam int ACC_W = SAMPLE_WIDTH + DC_SHIFT;
  localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(1) << (SAMPLE_WIDTH - 1 + DC_SHIFT);

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= ACC_INIT;
    end else if (adc_valid) begin
      acc <= acc + ACC_W'(adc_data) - (acc >> DC_SHIFT);
    end
  end

  assign dc = acc[ACC_W-1 -: SAMPLE_WIDTH];

endmodule

// File: rtl/sdft_feeder.sv
// Decimating front end for a sliding DFT.
// ADC samples are DC-centred, boxcar-averaged over DECIM samples, scaled by
// GAIN_SHIFT with saturation to DATA_W, held in a one-entry pending buffer and
// handed to the sliding DFT through a start/ready handshake.
// Build option: SDFT_FEEDER_DC_REMOVE_EN enables the IIR DC tracker;
// otherwise dc is fixed at mid-scale and DC_SHIFT is unused.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   adc_data        unsigned ADC sample, qualified by adc_valid
//   adc_valid       one-cycle sample strobe
//   sdft_ready      sliding DFT idle/ready
//   sdft_start      request to process sdft_sample
//   sdft_sample     signed decimated sample
//   overrun         one-cycle pulse per dropped decimated sample
//   overrun_count   saturating drop counter
//
// state   | meaning
// S_IDLE  | waiting for a pending sample and sdft_ready
// S_START | sdft_start asserted, waiting for the DFT to drop ready
// S_BUSY  | DFT processing, waiting for ready to return
module sdft_feeder
  import sdft_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DECIM        = 256,
  parameter int GAIN_SHIFT   = 4,
  parameter int DC_SHIFT     = 6
)(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [SAMPLE_WIDTH-1:0]  adc_data,
  input  logic                     adc_valid,
  input  logic                     sdft_ready,
  output logic                     sdft_start,
  output logic signed [DATA_W-1:0] sdft_sample,
  output logic                     overrun,
  output logic [7:0]               overrun_count
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int CNT_W = (LOG2D > 0) ? LOG2D : 1;
  localparam int CW    = centred_w(SAMPLE_WIDTH);
  localparam int AW    = CW + LOG2D;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [CW-1:0] SAT_MAX  = CW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [CW-1:0] SAT_MIN  = -SAT_MAX - CW'(1);
  localparam logic [SAMPLE_WIDTH-1:0] DC_MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic [SAMPLE_WIDTH-1:0] dc;

`ifdef SDFT_FEEDER_DC_REMOVE_EN
  dc_tracker #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DC_SHIFT     (DC_SHIFT)
  ) u_dc_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .dc        (dc)
  );
`else
  assign dc = DC_MID;
`endif

  logic signed [CW-1:0]     centred;
  logic signed [AW-1:0]     sum;
  logic signed [AW-1:0]     sum_next;
  logic [CNT_W-1:0]         cnt;
  logic                     win_done;
  logic signed [CW-1:0]     avg;
  logic signed [CW-1:0]     shifted;
  logic signed [DATA_W-1:0] scaled;

  assign centred  = $signed({1'b0, adc_data}) - $signed({1'b0, dc});
  assign sum_next = sum + AW'(centred);
  assign win_done = adc_valid && (cnt == CNT_LAST);
  // The window total is used directly on the completing sample so the
  // result reaches the pending buffer on that same edge.
  assign avg      = CW'(sum_next >>> LOG2D);
  assign shifted  = avg >>> GAIN_SHIFT;

  always_comb begin
    if (shifted > SAT_MAX)      scaled = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[DATA_W-1:0];
    else                        scaled = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum <= '0;
      cnt <= '0;
    end else if (adc_valid) begin
      if (win_done) begin
        sum <= '0;
        cnt <= '0;
      end else begin
        sum <= sum_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

  fsm_state_t               state;
  fsm_state_t               state_next;
  logic                     pend_full;
  logic signed [DATA_W-1:0] pend_data;
  logic                     consume;

  assign consume = (state == S_IDLE) && pend_full && sdft_ready;

  // A consume in the same cycle frees the slot, so a new result never
  // overruns against the entry that is being handed out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_full     <= 1'b0;
      pend_data     <= '0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      overrun <= 1'b0;
      if (win_done) begin
        if (!pend_full || consume) begin
          pend_full <= 1'b1;
          pend_data <= scaled;
        end else begin
          overrun <= 1'b1;
          if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end
      end else if (consume) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      sdft_sample <= '0;
    end else begin
      state <= state_next;
      if (consume) sdft_sample <= pend_data;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (pend_full && sdft_ready) state_next = S_START;
      S_START: if (!sdft_ready)             state_next = S_BUSY;
      S_BUSY:  if (sdft_ready)              state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sdft_start = (state == S_START);
  end

endmodule

// File: tb/tb_sdft_feeder.sv
// Directed bench for sdft_feeder with DECIM=4 at two gains (4 and 2).
// The DC-tracker settling scenario runs when SDFT_FEEDER_DC_REMOVE_EN is
// defined; the fixed-dc scenarios run otherwise.
module tb_sdft_feeder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        sdft_ready = 1'b1;

  logic        start_a, start_b;
  logic [7:0]  sample_a, sample_b;
  logic        ovr_a, ovr_b;
  logic [7:0]  cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdft_feeder #(
    .SAMPLE_WIDTH (12), .DATA_W (8), .DECIM (4), .GAIN_SHIFT (4), .DC_SHIFT (4)
  ) u_g4 (
    .clk (clk), .resetn (resetn), .adc_data (adc_data), .adc_valid (adc_valid),
    .sdft_ready (sdft_ready), .sdft_start (start_a), .sdft_sample (sample_a),
    .overrun (ovr_a), .overrun_count (cnt_a)
  );

  sdft_feeder #(
    .SAMPLE_WIDTH (12), .DATA_W (8), .DECIM (4), .GAIN_SHIFT (2), .DC_SHIFT (4)
  ) u_g2 (
    .clk (clk), .resetn (resetn), .adc_data (adc_data), .adc_valid (adc_valid),
    .sdft_ready (sdft_ready), .sdft_start (start_b), .sdft_sample (sample_b),
    .overrun (ovr_b), .overrun_count (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back valids; returns 1 ns into the cycle after the last valid.
  task automatic window(input logic [11:0] d, input int n, input bit ready_on_last);
    for (int i = 0; i < n; i++) begin
      tick();
      adc_valid = 1'b1;
      adc_data  = d;
      if (ready_on_last && i == n - 1) sdft_ready = 1'b1;
    end
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (start_a !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start_seen"}, start_a, 1);
  endtask

  task automatic finish_hs();
    tick();
    sdft_ready = 1'b0;
    tick();
    sdft_ready = 1'b1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_start", start_a, 0);
    check("rst_sample", sample_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_count", cnt_a, 0);
    resetn = 1'b1;

`ifdef SDFT_FEEDER_DC_REMOVE_EN
    for (int w = 0; w < 100; w++) begin
      window(12'd3000, 4, 1'b0);
      wait_start("dc_win");
      finish_hs();
    end
    check("dc_settle_within_1",
          ($signed(sample_a) >= -1 && $signed(sample_a) <= 1) ? 32'd1 : 32'd0, 1);
    check("dc_no_overrun", cnt_a, 0);
`else
    // 2208-2048=160 -> /16 = 10, /4 = 40; start two cycles after last valid
    window(12'd2208, 4, 1'b0);
    @(negedge clk);
    check("lat_n1_start", start_a, 0);
    @(negedge clk);
    check("lat_n2_start", start_a, 1);
    check("lat_sample_g4", sample_a, 10);
    check("lat_sample_g2", sample_b, 40);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_start", start_a, 1);
    end
    tick();
    sdft_ready = 1'b0;
    @(negedge clk);
    check("ready_low_start_still", start_a, 1);
    @(negedge clk);
    check("busy_start_low", start_a, 0);
    check("busy_sample", sample_a, 10);
    tick();
    sdft_ready = 1'b1;
    @(negedge clk);
    check("idle_sample", sample_a, 10);
    tick();

    // saturation: 2047 -> 127 both gains; -2048 -> -128 both gains
    window(12'd4095, 4, 1'b0);
    wait_start("sat_hi");
    check("sat_hi_g4", sample_a, 8'd127);
    check("sat_hi_g2", sample_b, 8'd127);
    finish_hs();
    window(12'd0, 4, 1'b0);
    wait_start("sat_lo");
    check("sat_lo_g4", sample_a, 8'h80);
    check("sat_lo_g2", sample_b, 8'h80);
    finish_hs();

    // overrun: ready held low over three windows
    sdft_ready = 1'b0;
    window(12'd2208, 4, 1'b0);
    @(negedge clk);
    check("ovr_first_none", ovr_a, 0);
    window(12'd4095, 4, 1'b0);
    @(negedge clk);
    check("ovr_pulse1", ovr_a, 1);
    @(negedge clk);
    check("ovr_pulse1_end", ovr_a, 0);
    check("ovr_count1", cnt_a, 1);
    check("ovr_no_start", start_a, 0);
    window(12'd0, 4, 1'b0);
    @(negedge clk);
    check("ovr_pulse2", ovr_a, 1);
    @(negedge clk);
    check("ovr_count2", cnt_a, 2);
    sdft_ready = 1'b1;
    wait_start("ovr_release");
    check("ovr_held_sample_g4", sample_a, 10);
    check("ovr_held_sample_g2", sample_b, 40);
    finish_hs();
    check("ovr_count_kept", cnt_a, 2);

    // consume and load on the same edge
    tick();
    sdft_ready = 1'b0;
    window(12'd4095, 4, 1'b0);
    window(12'd0, 4, 1'b1);
    @(negedge clk);
    check("simul_no_overrun", ovr_a, 0);
    check("simul_start", start_a, 1);
    check("simul_first_sample", sample_a, 8'd127);
    check("simul_count", cnt_a, 2);
    finish_hs();
    wait_start("simul_second");
    check("simul_second_sample", sample_a, 8'h80);
    finish_hs();

    // reset while busy with a half-filled window
    window(12'd2208, 4, 1'b0);
    wait_start("pre_rst");
    tick();
    sdft_ready = 1'b0;
    tick();
    window(12'd2208, 2, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_start", start_a, 0);
    check("mid_rst_sample", sample_a, 0);
    check("mid_rst_sample_g2", sample_b, 0);
    check("mid_rst_overrun", ovr_a, 0);
    check("mid_rst_count", cnt_a, 0);
    sdft_ready = 1'b1;
    tick();
    resetn = 1'b1;
    window(12'd2208, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_start", start_a, 0);
    end
    window(12'd2208, 1, 1'b0);
    @(negedge clk);
    check("post_rst_n1_start", start_a, 0);
    @(negedge clk);
    check("post_rst_n2_start", start_a, 1);
    check("post_rst_sample", sample_a, 10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
